// File: rtl/pwm_pkg.sv
// Shared constants and state encodings for the UART PWM loader and its receiver.
package pwm_pkg;

  localparam logic [4:0] HDR_TAG     = 5'b10100;
  localparam int         NUM_CH_BITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_CKS  = 2'd2,
    ST_EMIT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, LSB-first shift register.
module uart_rx
  import pwm_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       rx_busy
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  rx_state_t     state_reg, state_next;
  logic          meta_reg, sync_reg, prev_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          valid_reg, ferr_reg;
  logic          fall, half_hit, bit_hit;

  assign fall     = prev_reg & ~sync_reg;
  assign half_hit = (cnt_reg == CW'(HALF - 1));
  assign bit_hit  = (cnt_reg == CW'(CPB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RX_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A start bit that is high again at mid-bit is treated as a glitch.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RX_IDLE:  if (fall) state_next = RX_START;
      RX_START: if (half_hit) state_next = sync_reg ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_hit && (bit_idx_reg == 3'd7)) state_next = RX_STOP;
      RX_STOP:  if (bit_hit) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg    <= 1'b1;
      sync_reg    <= 1'b1;
      prev_reg    <= 1'b1;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      meta_reg  <= rx;
      sync_reg  <= meta_reg;
      prev_reg  <= sync_reg;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
      if ((state_reg == RX_IDLE) || ((state_reg == RX_START) && half_hit) || bit_hit) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if ((state_reg == RX_START) && half_hit) begin
        bit_idx_reg <= '0;
      end
      if ((state_reg == RX_DATA) && bit_hit) begin
        shift_reg   <= {sync_reg, shift_reg[7:1]};
        bit_idx_reg <= bit_idx_reg + 1'b1;
      end
      if ((state_reg == RX_STOP) && bit_hit) begin
        valid_reg <= sync_reg;
        ferr_reg  <= ~sync_reg;
      end
    end
  end

  always_comb begin
    rx_busy = (state_reg != RX_IDLE);
  end

  assign rx_byte  = shift_reg;
  assign rx_valid = valid_reg;
  assign rx_ferr  = ferr_reg;

endmodule

// File: rtl/uart_pwm_loader.sv
// UART command front end driving the PWM register-file write port (ADDRESS/DATA/LATCH).
// Build option: define PWM_LOADER_CKSUM_EN for 3-byte frames ending in an XOR checksum byte.
module uart_pwm_loader
  import pwm_pkg::*;
#(
  parameter int CLK_HZ       = 100000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       CLK_100MHz,
  input  logic       RST_N,
  input  logic       UART_RX,
  output logic [2:0] ADDRESS,
  output logic [7:0] DATA,
  output logic       LATCH,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int CPB      = CLK_HZ / BAUD;
  localparam int TO_LIMIT = TIMEOUT_BITS * CPB;
  localparam int TW       = $clog2(TO_LIMIT + 1);

`ifdef PWM_LOADER_CKSUM_EN
  localparam state_t AFTER_DATA = ST_CKS;
`else
  localparam state_t AFTER_DATA = ST_EMIT;
`endif

  logic [7:0]             rx_byte;
  logic                   rx_valid, rx_ferr, rx_busy;
  state_t                 state_reg, state_next;
  logic                   err_next, waiting, timeout;
  logic [NUM_CH_BITS-1:0] addr_reg, address_reg;
  logic [7:0]             data_reg, emit_data;
  logic                   frame_err_reg;
  logic [TW-1:0]          to_cnt_reg;
`ifdef PWM_LOADER_CKSUM_EN
  logic [7:0]             data_hold_reg;
`endif

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk      (CLK_100MHz),
    .rst_n    (RST_N),
    .rx       (UART_RX),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .rx_busy  (rx_busy)
  );

  // The inter-byte timer is frozen while a byte is arriving, so only idle line time counts.
  assign waiting = (state_reg == ST_HDR) || (state_reg == ST_CKS);
  assign timeout = waiting && !rx_busy && !rx_valid && (to_cnt_reg == TW'(TO_LIMIT - 1));

  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    err_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_byte[7:3] == HDR_TAG) state_next = ST_HDR;
          else                          err_next   = 1'b1;
        end
      end
      ST_HDR:  if (rx_valid) state_next = AFTER_DATA;
`ifdef PWM_LOADER_CKSUM_EN
      ST_CKS: begin
        if (rx_valid) begin
          if (rx_byte == ({HDR_TAG, addr_reg} ^ data_hold_reg)) begin
            state_next = ST_EMIT;
          end else begin
            state_next = ST_IDLE;
            err_next   = 1'b1;
          end
        end
      end
`endif
      ST_EMIT: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (rx_ferr || timeout) begin
      state_next = ST_IDLE;
      err_next   = 1'b1;
    end
  end

  always_comb begin
    LATCH = (state_reg == ST_EMIT);
    BUSY  = (state_reg != ST_IDLE);
  end

`ifdef PWM_LOADER_CKSUM_EN
  assign emit_data = data_hold_reg;
`else
  assign emit_data = rx_byte;
`endif

  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      addr_reg      <= '0;
      address_reg   <= '0;
      data_reg      <= '0;
      frame_err_reg <= 1'b0;
      to_cnt_reg    <= '0;
`ifdef PWM_LOADER_CKSUM_EN
      data_hold_reg <= '0;
`endif
    end else begin
      frame_err_reg <= err_next;
      if ((state_reg == ST_IDLE) && rx_valid) begin
        addr_reg <= rx_byte[NUM_CH_BITS-1:0];
      end
`ifdef PWM_LOADER_CKSUM_EN
      if ((state_reg == ST_HDR) && rx_valid) begin
        data_hold_reg <= rx_byte;
      end
`endif
      // Outputs are loaded on entry to EMIT so they are valid in the LATCH cycle.
      if ((state_next == ST_EMIT) && (state_reg != ST_EMIT)) begin
        address_reg <= addr_reg;
        data_reg    <= emit_data;
      end
      if (rx_valid) begin
        to_cnt_reg <= TW'(1);
      end else if (waiting && !rx_busy) begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end
    end
  end

  assign ADDRESS   = address_reg;
  assign DATA      = data_reg;
  assign FRAME_ERR = frame_err_reg;

endmodule

// File: tb/tb_uart_pwm_loader.sv
// Directed and randomized bench for uart_pwm_loader against a byte-level command model.
module tb_uart_pwm_loader;

  localparam int CLK_HZ       = 1000;
  localparam int BAUD         = 100;
  localparam int TIMEOUT_BITS = 20;
  localparam int CPB          = CLK_HZ / BAUD;
  localparam logic [4:0] TAG  = 5'b10100;
`ifdef PWM_LOADER_CKSUM_EN
  localparam int FRAME_LEN = 3;
`else
  localparam int FRAME_LEN = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       uart_rx = 1'b1;
  logic [2:0] address;
  logic [7:0] data;
  logic       latch, frame_err, busy;

  int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
  int cyc = 0;
  int latch_cnt = 0, ferr_cnt = 0, rv_cnt = 0;
  int rv_cyc = 0, ferr_cyc = 0, latch_lat = -1;

  int         m_latch = 0, m_err = 0, m_pos = 0;
  logic [7:0] m_hdr = 8'h00, m_dat = 8'h00;
  logic [2:0] exp_addr = 3'd0;
  logic [7:0] exp_data = 8'h00;

  uart_pwm_loader #(
    .CLK_HZ       (CLK_HZ),
    .BAUD         (BAUD),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .CLK_100MHz (clk),
    .RST_N      (rst_n),
    .UART_RX    (uart_rx),
    .ADDRESS    (address),
    .DATA       (data),
    .LATCH      (latch),
    .FRAME_ERR  (frame_err),
    .BUSY       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dut.u_rx.rx_valid) begin
      rv_cnt++;
      rv_cyc = cyc;
    end
    if (latch) begin
      latch_cnt++;
      latch_lat = cyc - rv_cyc;
    end
    if (frame_err) begin
      ferr_cnt++;
      ferr_cyc = cyc;
    end
    if (latch || frame_err) chk("latch_ferr_exclusive", 32'(latch && frame_err), 32'd0);
  end

  // Command model: header byte, data byte, optional XOR checksum; any bad byte drops the frame.
  task automatic model_emit();
    m_latch++;
    exp_addr = m_hdr[2:0];
    exp_data = m_dat;
    m_pos    = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_err++;
      m_pos = 0;
    end else if (m_pos == 0) begin
      if (b[7:3] == TAG) begin
        m_hdr = b;
        m_pos = 1;
      end else begin
        m_err++;
      end
    end else if (m_pos == 1) begin
      m_dat = b;
      if (FRAME_LEN == 2) model_emit();
      else m_pos = 2;
    end else begin
      if (b == (m_hdr ^ m_dat)) model_emit();
      else begin
        m_err++;
        m_pos = 0;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    uart_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_time(input logic v);
    uart_rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic tx(input logic [7:0] b, input bit stop_ok);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_ok);
    uart_rx = 1'b1;
    model_byte(b, stop_ok);
  endtask

  task automatic send_cmd(input logic [7:0] h, input logic [7:0] d);
    tx(h, 1'b1);
    chk("busy_mid_frame", 32'(busy), 32'd1);
    tx(d, 1'b1);
    if (FRAME_LEN == 3) tx(h ^ d, 1'b1);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_latches"}, latch_cnt, m_latch);
    chk({tag, "_ferrs"}, ferr_cnt, m_err);
    chk({tag, "_address"}, 32'(address), 32'(exp_addr));
    chk({tag, "_data"}, 32'(data), 32'(exp_data));
    chk({tag, "_busy"}, 32'(busy), 32'(m_pos != 0));
  endtask

  initial begin
    int         kind;
    int         rv_before;
    logic [7:0] h, d, b;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_address", 32'(address), 32'd0);
    chk("reset_data", 32'(data), 32'd0);
    chk("reset_latch", 32'(latch), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle_cycles(5);

    send_cmd(8'hA5, 8'h80);
    idle_cycles(5);
    check_outputs("cmd_a5");
    chk("cmd_a5_addr_const", 32'(address), 32'd5);
    chk("cmd_a5_data_const", 32'(data), 32'h80);
    chk("cmd_a5_latch_latency", latch_lat, 32'd1);

    tx(8'h3C, 1'b1);
    idle_cycles(5);
    check_outputs("bad_header");
    send_cmd(8'hA2, 8'h10);
    idle_cycles(5);
    check_outputs("cmd_a2");
    chk("cmd_a2_data_const", 32'(data), 32'h10);

    tx(8'hA1, 1'b0);
    idle_cycles(5);
    check_outputs("stop_err");

    tx(8'hA7, 1'b1);
    idle_cycles(190);
    chk("timeout_not_early_busy", 32'(busy), 32'd1);
    chk("timeout_not_early_ferr", ferr_cnt, m_err);
    idle_cycles(20);
    m_err++;
    m_pos = 0;
    chk("timeout_latency", ferr_cyc - rv_cyc, TIMEOUT_BITS * CPB);
    check_outputs("timeout");

    rv_before = rv_cnt;
    uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle_cycles(30);
    chk("glitch_no_rx_valid", rv_cnt, rv_before);
    check_outputs("glitch");

    tx(8'hA4, 1'b1);
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(i[0]);
    rst_n = 1'b0;
    uart_rx = 1'b1;
    @(posedge clk);
    #1;
    m_pos = 0;
    exp_addr = 3'd0;
    exp_data = 8'h00;
    chk("midreset_latch", 32'(latch), 32'd0);
    check_outputs("midreset");
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(150);
    check_outputs("post_reset");
    tx(8'h80, 1'b1);
    idle_cycles(5);
    check_outputs("first_after_reset");
    send_cmd(8'hA6, 8'h5A);
    idle_cycles(5);
    check_outputs("cmd_a6");

`ifdef PWM_LOADER_CKSUM_EN
    tx(8'hA3, 1'b1);
    tx(8'h55, 1'b1);
    tx(8'hF6, 1'b1);
    idle_cycles(5);
    check_outputs("cksum_good");
    chk("cksum_good_addr_const", 32'(address), 32'd3);
    chk("cksum_good_data_const", 32'(data), 32'h55);
    tx(8'hA3, 1'b1);
    tx(8'h55, 1'b1);
    tx(8'h00, 1'b1);
    idle_cycles(5);
    check_outputs("cksum_bad");
`endif

    for (int it = 0; it < 16; it++) begin
      kind = $urandom_range(0, 3);
      h    = {TAG, 3'($urandom_range(0, 7))};
      d    = 8'($urandom);
      case (kind)
        0: send_cmd(h, d);
        1: begin
          b = 8'($urandom);
          if (b[7:3] == TAG) b[7] = ~b[7];
          tx(b, 1'b1);
        end
        2: tx(h, 1'b0);
        default: begin
          if (FRAME_LEN == 3) begin
            tx(h, 1'b1);
            tx(d, 1'b1);
            tx(h ^ d ^ 8'($urandom_range(1, 255)), 1'b1);
          end else begin
            send_cmd(h, d);
          end
        end
      endcase
      idle_cycles(5);
      check_outputs($sformatf("rand%0d_k%0d", it, kind));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
